// File: rtl/data_memory.sv
// Line-wide main data memory behind the data cache: one 128-bit line per request,
// fixed access latency, busywait handshake (IDLE -> BUSY -> DONE).
module data_memory #(
    parameter int LINE_ADDR_W = 6,
    parameter int LATENCY     = 5,
    parameter int CNT_W       = 3
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         MEM_READ,
    input  logic         MEM_WRITE,
    input  logic [27:0]  MEM_ADDRESS,
    input  logic [127:0] MEM_WRITEDATA,
    output logic [127:0] MEM_READDATA,
    output logic         MEM_BUSYWAIT
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   wr_q, wr_d;
    logic [LINE_ADDR_W-1:0] addr_q, addr_d;
    logic [127:0]           wdata_q, wdata_d;
    logic [127:0]           rdata_q, rdata_d;
    logic                   mem_we;
    logic                   busy;

    logic [127:0] mem_q [2**LINE_ADDR_W];

    // Upper line-address bits are deliberately not decoded: lines alias.
    logic unused_addr;
    assign unused_addr = ^MEM_ADDRESS[27:LINE_ADDR_W];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        mem_we  = 1'b0;
        busy    = 1'b0;
        case (state_q)
            IDLE: begin
                if (MEM_READ || MEM_WRITE) begin
                    busy    = 1'b1;
                    wr_d    = MEM_WRITE;  // read+write together counts as a write
                    addr_d  = MEM_ADDRESS[LINE_ADDR_W-1:0];
                    wdata_d = MEM_WRITEDATA;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                busy = 1'b1;
                if (cnt_q == '0) begin
                    state_d = DONE;
                    if (wr_q) mem_we  = 1'b1;
                    else      rdata_d = mem_q[addr_q];
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign MEM_BUSYWAIT = busy && RESET;
    assign MEM_READDATA = rdata_q;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Array contents survive reset; a reset during BUSY simply drops the write.
    always_ff @(posedge CLK) begin
        if (RESET && mem_we) mem_q[addr_q] <= wdata_q;
    end

endmodule

// File: tb/tb_data_memory.sv
// Randomized scoreboard bench for data_memory: driver pushes expected responses,
// monitor pops and checks on each busywait falling edge.
module tb_data_memory;
    localparam int LAW = 6;
    localparam int LAT = 5;

    logic         CLK = 1'b0;
    logic         RESET = 1'b0;
    logic         MEM_READ = 1'b0;
    logic         MEM_WRITE = 1'b0;
    logic [27:0]  MEM_ADDRESS = '0;
    logic [127:0] MEM_WRITEDATA = '0;
    logic [127:0] MEM_READDATA;
    logic         MEM_BUSYWAIT;

    data_memory #(.LINE_ADDR_W(LAW), .LATENCY(LAT), .CNT_W(3)) dut (
        .CLK(CLK), .RESET(RESET), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
        .MEM_ADDRESS(MEM_ADDRESS), .MEM_WRITEDATA(MEM_WRITEDATA),
        .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [127:0] rdata;
        bit           chk_period;
        string        name;
    } exp_t;

    exp_t         sb[$];
    int           n_cmp = 0;
    int           n_bad = 0;
    logic [127:0] model_mem [int];
    logic [127:0] model_rd = '0;

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    // Reference model: whole-line store indexed modulo the number of decoded lines.
    function automatic void model_req(input bit rd, input bit wr, input logic [27:0] a,
                                      input logic [127:0] d, input bit per, input string nm);
        exp_t e;
        int line = int'(a) % (1 << LAW);
        if (wr) model_mem[line] = d;
        else if (rd) model_rd = model_mem[line];
        e.rdata = model_rd;
        e.chk_period = per;
        e.name = nm;
        sb.push_back(e);
    endfunction

    // Monitor: measures busywait run length and checks readdata when busywait falls.
    initial begin
        int  cyc = 0, run = 0, rise = 0, prev_rise = 0;
        bit  prev_busy = 0;
        exp_t e;
        forever begin
            @(negedge CLK);
            cyc++;
            if (!RESET) begin
                run = 0;
                prev_busy = 0;
            end else begin
                if (MEM_BUSYWAIT) begin
                    if (!prev_busy) begin
                        prev_rise = rise;
                        rise = cyc;
                    end
                    run++;
                end else if (prev_busy) begin
                    if (sb.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_completion: got completion expected none");
                    end else begin
                        e = sb.pop_front();
                        check({e.name, "_busy_len"}, 128'(run), 128'(LAT + 1));
                        check({e.name, "_rdata"}, MEM_READDATA, e.rdata);
                        if (e.chk_period)
                            check({e.name, "_period"}, 128'(rise - prev_rise), 128'(LAT + 2));
                    end
                    run = 0;
                end
                prev_busy = MEM_BUSYWAIT;
            end
        end
    end

    task automatic wait_done(input string nm);
        int k;
        for (k = 0; k < 20; k++) begin
            @(negedge CLK);
            if (!MEM_BUSYWAIT) break;
        end
        if (k == 20) begin
            n_cmp++; n_bad++;
            $display("FAIL %s_timeout: got busywait stuck high expected low within 20 cycles", nm);
        end
    endtask

    // One request; address/data are scrambled after acceptance to prove latching.
    task automatic do_req(input bit rd, input bit wr, input logic [27:0] a,
                          input logic [127:0] d, input string nm);
        @(posedge CLK); #1;
        MEM_READ = rd; MEM_WRITE = wr; MEM_ADDRESS = a; MEM_WRITEDATA = d;
        model_req(rd, wr, a, d, 1'b0, nm);
        @(posedge CLK); #1;
        MEM_ADDRESS = 28'($urandom); MEM_WRITEDATA = rnd128();
        wait_done(nm);
        MEM_READ = 0; MEM_WRITE = 0;
    endtask

    initial begin
        logic [127:0] a_val, b_val, c_val, d_val;
        // Reset for two cycles with no requests.
        RESET = 0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("reset_busywait", 128'(MEM_BUSYWAIT), 128'(0));
        check("reset_readdata", MEM_READDATA, '0);
        RESET = 1;

        do_req(0, 1, 28'h05, 128'h0123456789ABCDEF0123456789ABCDEF, "wr05");
        do_req(1, 0, 28'h05, '0, "rd05");

        for (int i = 0; i < (1 << LAW); i++)
            do_req(0, 1, 28'(i) | (28'($urandom) << LAW), rnd128(), "fill");

        // Held read through DONE: one access per LATENCY+2 cycles.
        @(posedge CLK); #1;
        MEM_READ = 1; MEM_ADDRESS = 28'h05;
        for (int i = 0; i < 4; i++) model_req(1, 0, 28'h05, '0, i > 0, "b2b");
        repeat (4 * (LAT + 2) - 1) @(posedge CLK);
        @(negedge CLK);
        MEM_READ = 0;
        wait_done("b2b_tail");

        // Reset aborts an in-flight write.
        a_val = rnd128(); b_val = rnd128();
        do_req(0, 1, 28'h03, a_val, "wr03A");
        @(posedge CLK); #1;
        MEM_WRITE = 1; MEM_ADDRESS = 28'h03; MEM_WRITEDATA = b_val;
        repeat (2) @(posedge CLK);
        #1 RESET = 0;
        @(negedge CLK);
        check("abort_busywait_in_reset", 128'(MEM_BUSYWAIT), 128'(0));
        @(posedge CLK); #1;
        check("abort_readdata_zero", MEM_READDATA, '0);
        MEM_WRITE = 0; RESET = 1;
        model_rd = '0;
        @(negedge CLK);
        check("abort_busywait_after", 128'(MEM_BUSYWAIT), 128'(0));
        do_req(1, 0, 28'h03, '0, "rd03");

        // Read+write together is a write.
        c_val = rnd128();
        do_req(1, 0, 28'h05, '0, "rd05b");
        do_req(1, 1, 28'h0A, c_val, "rw0A");
        do_req(1, 0, 28'h0A, '0, "rd0A");

        // Aliasing modulo 64 lines.
        d_val = rnd128();
        do_req(0, 1, 28'h41, d_val, "wr41");
        do_req(1, 0, 28'h01, '0, "rd01");

        for (int i = 0; i < 40; i++) begin
            bit wr = 1'($urandom);
            bit rd = 1'($urandom) | !wr;
            do_req(rd, wr, 28'($urandom), rnd128(), "rand");
        end

        repeat (3) @(posedge CLK);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
